// File: rtl/parity_accumulator.sv
// rtl/parity_accumulator.sv - per-packet parity generator/checker with saturating beat and error counters
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_valid_i/s_ready_o     input beat handshake
//   s_data_i, s_last_i      beat data, final-beat marker
//   s_par_i                 expected parity, sampled on the last beat only
//   odd_i                   parity mode (0 even, 1 odd), sampled on a packet's first beat
//   clr_i                   synchronous clear of err_cnt_o (wins over an increment)
//   m_valid_o/m_ready_i     result handshake
//   m_parity_o, m_err_o     generated parity, mismatch against s_par_i
//   m_beats_o               saturating beat count of the packet
//   err_cnt_o               saturating count of mismatching packets

module parity_accumulator #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  input  logic              s_par_i,
  input  logic              odd_i,
  input  logic              clr_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_parity_o,
  output logic              m_err_o,
  output logic [CNT_W-1:0]  m_beats_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic               acc_q, acc_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               m_parity_q, m_parity_d;
  logic               m_err_q, m_err_d;
  logic [CNT_W-1:0]   m_beats_q, m_beats_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               ready;
  logic               accept;
  logic               in_idle;
  logic               pkt_mode;
  logic               acc_next;
  logic [CNT_W-1:0]   cnt_base;
  logic [CNT_W-1:0]   cnt_next;
  logic               par_next;
  logic               mismatch;

  // Datapath for the beat currently offered. A beat taken in IDLE starts a
  // fresh packet, so it sees a zero accumulator, zero count and the live mode.
  always_comb begin
    ready    = (state_q != HOLD);
    accept   = s_valid_i & ready;
    in_idle  = (state_q == IDLE);
    pkt_mode = in_idle ? odd_i : mode_q;
    acc_next = (in_idle ? 1'b0 : acc_q) ^ (^s_data_i);
    cnt_base = in_idle ? '0 : beats_q;
    cnt_next = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_ONE;
    // XOR with the mode makes ones(data) + parity even (mode 0) or odd (mode 1).
    par_next = acc_next ^ pkt_mode;
    mismatch = par_next ^ s_par_i;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    beats_d    = beats_q;
    m_parity_d = m_parity_q;
    m_err_d    = m_err_q;
    m_beats_d  = m_beats_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_next;
          mode_d  = pkt_mode;
          beats_d = cnt_next;
          if (s_last_i) begin
            m_parity_d = par_next;
            m_err_d    = mismatch;
            m_beats_d  = cnt_next;
            if (mismatch && (err_cnt_q != CNT_MAX)) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (m_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr_i) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      mode_q     <= 1'b0;
      beats_q    <= '0;
      m_parity_q <= 1'b0;
      m_err_q    <= 1'b0;
      m_beats_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      beats_q    <= beats_d;
      m_parity_q <= m_parity_d;
      m_err_q    <= m_err_d;
      m_beats_q  <= m_beats_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_ready_o  = ready;
  assign m_valid_o  = (state_q == HOLD);
  assign m_parity_o = m_parity_q;
  assign m_err_o    = m_err_q;
  assign m_beats_o  = m_beats_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_parity_accumulator.sv
// tb/tb_parity_accumulator.sv - scoreboard testbench for parity_accumulator

module tb_parity_accumulator;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [15:0] s_data_i;
  logic        s_last_i;
  logic        s_par_i;
  logic        odd_i;
  logic        clr_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_parity_o;
  logic        m_err_o;
  logic [7:0]  m_beats_o;
  logic [7:0]  err_cnt_o;

  parity_accumulator #(.DATA_W(16), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .s_par_i    (s_par_i),
    .odd_i      (odd_i),
    .clr_i      (clr_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_parity_o (m_parity_o),
    .m_err_o    (m_err_o),
    .m_beats_o  (m_beats_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       par;
    logic       err;
    logic [7:0] beats;
    logic [7:0] errcnt;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] dq[$];
  int          checks = 0;
  int          failures = 0;
  int          err_model = 0;
  bit          ready_manual = 1'b0;
  bit          gaps = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares each result on its first valid cycle, then checks it
  // stays frozen for as long as the sink stalls.
  bit         holding = 1'b0;
  logic       snap_par, snap_err;
  logic [7:0] snap_beats;
  always @(negedge clk) begin
    if (rst_i || !m_valid_o) begin
      holding = 1'b0;
    end else begin
      if (!holding) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("m_parity", m_parity_o, e.par);
          chk("m_err", m_err_o, e.err);
          chk("m_beats", m_beats_o, e.beats);
          chk("err_cnt", err_cnt_o, e.errcnt);
        end
        snap_par   = m_parity_o;
        snap_err   = m_err_o;
        snap_beats = m_beats_o;
      end else begin
        chk("hold_stable", {m_parity_o, m_err_o, m_beats_o}, {snap_par, snap_err, snap_beats});
      end
      holding = !m_ready_i;
    end
  end

  initial begin
    m_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ready_manual) m_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    s_valid_i = 1'b0;
    clr_i     = 1'b0;
    s_data_i  = 16'($urandom());
    s_last_i  = 1'($urandom());
    s_par_i   = 1'($urandom());
    odd_i     = 1'($urandom());
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input logic [15:0] d, input bit last, input bit odd,
                           input bit par, input bit clr);
    int t = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    odd_i     = odd;
    s_par_i   = par;
    clr_i     = clr;
    @(negedge clk);
    while (!s_ready_o && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Reference: parity from the total count of ones across the packet.
  task automatic send_pkt(input int n, input bit odd, input bit par, input bit clr_last);
    int          ones = 0;
    logic [15:0] d;
    exp_t        e;
    for (int i = 0; i < n; i++) begin
      if (dq.size() > 0) d = dq.pop_front();
      else d = 16'($urandom());
      ones += $countones(d);
      if (i == n - 1) begin
        e.par   = ((ones % 2) == 1) ^ odd;
        e.err   = (e.par != par);
        e.beats = (n > 255) ? 8'd255 : 8'(n);
        if (e.err && err_model < 255) err_model++;
        if (clr_last) err_model = 0;
        e.errcnt = 8'(err_model);
        expq.push_back(e);
        send_beat(d, 1'b1, (i == 0) ? odd : 1'($urandom()), par, clr_last);
        chk("latency_valid", m_valid_o, 1);
      end else begin
        send_beat(d, 1'b0, (i == 0) ? odd : 1'($urandom()), 1'($urandom()), 1'b0);
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((expq.size() != 0 || m_valid_o) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] d;
    bit          o;
    rst_i = 1'b1;
    idle_inputs();
    #12;
    chk("rst_s_ready", s_ready_o, 1);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_parity", m_parity_o, 0);
    chk("rst_m_err", m_err_o, 0);
    chk("rst_m_beats", m_beats_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    @(posedge clk);
    #3 rst_i = 1'b0;
    @(posedge clk);
    #1;

    // even, single beat 0x0001, par 1
    dq.push_back(16'h0001);
    send_pkt(1, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // odd, FFFF/0003/8000, par 1 -> parity 0, mismatch
    dq.push_back(16'hFFFF);
    dq.push_back(16'h0003);
    dq.push_back(16'h8000);
    send_pkt(3, 1'b1, 1'b1, 1'b0);
    wait_drain();
    chk("err_cnt_after_mismatch", err_cnt_o, 1);

    // backpressure: result held for 5 cycles
    ready_manual = 1'b1;
    m_ready_i    = 1'b0;
    dq.push_back(16'h00F0);
    send_pkt(1, 1'b0, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_s_ready", s_ready_o, 0);
      chk("stall_m_valid", m_valid_o, 1);
    end
    @(posedge clk);
    #1 m_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("release_s_ready", s_ready_o, 1);
    chk("release_m_valid", m_valid_o, 0);
    m_ready_i    = 1'b0;
    ready_manual = 1'b0;

    // clear coinciding with a mismatching last beat
    dq.push_back(16'h0003);
    send_pkt(1, 1'b0, 1'b1, 1'b1);
    wait_drain();
    chk("clr_err_cnt", err_cnt_o, 0);

    // 300-beat packet saturates the beat count
    gaps = 1'b0;
    send_pkt(300, 1'($urandom()), 1'($urandom()), 1'b0);
    wait_drain();

    // 256 mismatching packets saturate the error counter
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom());
      o = 1'($urandom());
      dq.push_back(d);
      send_pkt(1, o, (($countones(d) % 2) == 1) ^ o ^ 1'b1, 1'b0);
    end
    wait_drain();
    chk("err_cnt_saturated", err_cnt_o, 255);

    // random packets with idle gaps
    gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_pkt($urandom_range(1, 6), 1'($urandom()), 1'($urandom()), 1'b0);
    end
    wait_drain();

    // reset mid-packet after two beats
    send_beat(16'($urandom()), 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(16'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_s_ready", s_ready_o, 1);
    chk("arst_m_valid", m_valid_o, 0);
    chk("arst_m_parity", m_parity_o, 0);
    chk("arst_m_err", m_err_o, 0);
    chk("arst_m_beats", m_beats_o, 0);
    chk("arst_err_cnt", err_cnt_o, 0);
    err_model = 0;
    @(posedge clk);
    #3 rst_i = 1'b0;
    @(posedge clk);
    #1;
    dq.push_back(16'h0000);
    send_pkt(1, 1'b0, 1'b0, 1'b0);
    wait_drain();

    for (int i = 0; i < 10; i++) begin
      send_pkt($urandom_range(1, 4), 1'($urandom()), 1'($urandom()), 1'($urandom_range(0, 3) == 0));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_accumulator.md
PARITY_ACCUMULATOR -- requirements
Module: parity_accumulator

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning width of each data beat (legal range 1 to 64).
REQ-002 SHALL provide parameter CNT_W, default 8, meaning width of the beat counter and the error counter.
REQ-003 SHALL provide port clk_i, input, 1, the single clock; all logic rising-edge triggered.
REQ-004 SHALL provide port rst_i, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL provide port s_valid_i, input, 1, input beat valid.
REQ-006 SHALL provide port s_ready_o, output, 1, input beat ready.
REQ-007 SHALL provide port s_data_i, input, DATA_W, data beat.
REQ-008 SHALL provide port s_last_i, input, 1, final beat of packet.
REQ-009 SHALL provide port s_par_i, input, 1, expected parity bit, meaningful on the last beat only.
REQ-010 SHALL provide port odd_i, input, 1, mode select: 0 = even parity, 1 = odd parity.
REQ-011 SHALL provide port clr_i, input, 1, synchronous clear of err_cnt_o.
REQ-012 SHALL provide port m_valid_o, output, 1, result valid.
REQ-013 SHALL provide port m_ready_i, input, 1, result ready.
REQ-014 SHALL provide port m_parity_o, output, 1, generated packet parity bit.
REQ-015 SHALL provide port m_err_o, output, 1, result mismatch: m_parity_o != expected.
REQ-016 SHALL provide port m_beats_o, output, CNT_W, number of beats in the packet (saturating).
REQ-017 SHALL provide port err_cnt_o, output, CNT_W, count of mismatching packets (saturating).

Function
REQ-018 SHALL implement the states IDLE, ACCUM and HOLD.
REQ-019 SHALL accept a beat only when s_valid_i and s_ready_o are both 1 in the same cycle.
REQ-020 SHALL drive s_ready_o = 1 in IDLE and ACCUM, and 0 in HOLD (no same-cycle bypass).
REQ-021 SHALL, on a beat accepted in IDLE, latch odd_i as the packet mode; odd_i SHALL be ignored at every other time.
REQ-022 SHALL, on each accepted beat, XOR-reduce s_data_i and fold the result into a running accumulator; the accumulator SHALL be zero at packet start.
REQ-023 SHALL count accepted beats per packet, starting at 1 for the first beat and saturating at 2^CNT_W-1.
REQ-024 SHALL transition IDLE->ACCUM on an accepted non-last beat, and IDLE->HOLD or ACCUM->HOLD on an accepted last beat.
REQ-025 SHALL set the result on the last beat to (accumulated XOR including that beat) XOR latched mode, so that total ones plus the parity bit is even in even mode and odd in odd mode.
REQ-026 SHALL register m_parity_o, m_err_o and m_beats_o on the last-beat accept edge; m_valid_o SHALL assert in the following cycle (1-cycle latency).
REQ-027 SHALL hold m_valid_o and all m_* outputs stable in HOLD until m_ready_i = 1, then return to IDLE on that edge.
REQ-028 SHALL increment err_cnt_o on the last-beat accept edge when the mismatch is 1, saturating at 2^CNT_W-1.
REQ-029 SHALL let clr_i win when it coincides with an increment, leaving err_cnt_o = 0.
REQ-030 SHALL accept single-beat packets (s_last_i = 1 on the first beat) from IDLE straight to HOLD.
REQ-031 SHALL ignore s_data_i, s_last_i and s_par_i whenever no beat is accepted.

Reset
REQ-032 SHALL, while rst_i = 1, immediately force: state IDLE, accumulator 0, s_ready_o 1, m_valid_o 0, m_parity_o 0, m_err_o 0, m_beats_o 0, err_cnt_o 0.
REQ-033 SHALL discard any partial packet or held result on reset; the first accepted beat after rst_i deasserts SHALL start a new packet.

Verification
REQ-034 SHALL verify: even mode, single beat 0x0001, s_par_i=1 -> next cycle m_valid_o=1, m_parity_o=1, m_err_o=0, m_beats_o=1.
REQ-035 SHALL verify: odd mode, beats 0xFFFF, 0x0003, 0x8000 (last), s_par_i=1 -> m_parity_o=0, m_err_o=1, m_beats_o=3, err_cnt_o=1.
REQ-036 SHALL verify: m_ready_i held 0 for 5 cycles after a result -> m_valid_o=1 and outputs unchanged, s_ready_o=0 throughout; m_ready_i=1 -> IDLE, s_ready_o=1 next cycle.
REQ-037 SHALL verify: CNT_W=8, 300-beat packet -> m_beats_o=255; 256 mismatching packets -> err_cnt_o stays 255.
REQ-038 SHALL verify: rst_i pulsed mid-packet after 2 beats -> outputs reset asynchronously; the next single-beat packet 0x0000 in even mode -> m_parity_o=0, m_beats_o=1.
REQ-039 SHALL verify: clr_i asserted in the same cycle as a mismatching last beat -> err_cnt_o=0 while m_err_o=1.
